// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon tone scheduler.
//   state_t     : scheduler FSM states
//   owner_t     : encoding of who currently owns the tone/LED datapath
//   JINGLE_SEQ  : game-over jingle note order, element 0 plays first
//   *_TICKS_DEF : default tick counts for a 25 MHz-class clock
package simon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNOTE,
    ST_SGAP,
    ST_PNOTE,
    ST_JINGLE,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_SIMON  = 2'd1,
    OWN_PLAYER = 2'd2,
    OWN_JINGLE = 2'd3
  } owner_t;

  localparam int unsigned NOTE_TICKS_DEF  = 25_000_000;
  localparam int unsigned GAP_TICKS_DEF   = 5_000_000;
  localparam int unsigned MIN_TICKS_DEF   = 5_000_000;
  localparam int unsigned JINGLE_STEP_DEF = 10_000_000;

  localparam int unsigned JINGLE_LEN = 4;

  // Packed so JINGLE_SEQ[i] is step i: plays 3, 2, 1, 0.
  localparam logic [JINGLE_LEN-1:0][1:0] JINGLE_SEQ = {2'd0, 2'd1, 2'd2, 2'd3};

  function automatic int unsigned max_ticks(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/tick_timer.sv
// Loadable down-counter with a registered one-cycle expire flag.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val (takes priority over counting)
//   load_val   : number of cycles until expire; expire is high in the
//                load_val-th cycle after the load edge
//   expire     : one-cycle pulse in the final counted cycle
module tick_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] count;

  // Expire is registered one cycle early (count==2 about to become 1)
  // so it lines up with the cycle in which count holds 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      expire <= 1'b0;
    end else if (load) begin
      count  <= load_val;
      expire <= (load_val == W'(1));
    end else if (count != '0) begin
      count  <= count - W'(1);
      expire <= (count == W'(2));
    end else begin
      expire <= 1'b0;
    end
  end

endmodule

// File: rtl/tone_scheduler.sv
// Arbitrates the tone/LED datapath between Simon, the player and the
// game-over jingle.
//   clk, reset              : clock, async active-low reset
//   simon_req/simon_num     : Simon note request (held until simon_ack) and index
//   player_req/player_num   : player button level and index
//   game_over               : game-over level; starts the jingle
//   num, play               : note index and enable to the tone/LED datapath
//   simon_ack               : one-cycle pulse after a Simon note and its gap
//   owner                   : 0 none, 1 Simon, 2 player, 3 jingle
//   jingle_done             : high once the jingle finished, until game_over falls
module tone_scheduler
  import simon_pkg::*;
#(
  parameter int unsigned NOTE_TICKS  = NOTE_TICKS_DEF,
  parameter int unsigned GAP_TICKS   = GAP_TICKS_DEF,
  parameter int unsigned MIN_TICKS   = MIN_TICKS_DEF,
  parameter int unsigned JINGLE_STEP = JINGLE_STEP_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       simon_req,
  input  logic [1:0] simon_num,
  input  logic       player_req,
  input  logic [1:0] player_num,
  input  logic       game_over,
  output logic [1:0] num,
  output logic       play,
  output logic       simon_ack,
  output logic [1:0] owner,
  output logic       jingle_done
);

  localparam int unsigned TW = $clog2(max_ticks(NOTE_TICKS, GAP_TICKS, MIN_TICKS, JINGLE_STEP) + 1);

  state_t      state, state_n;
  logic [1:0]  step, step_n;
  logic        min_done, min_done_n;
  logic [1:0]  num_n;
  logic        ack_n;
  logic        play_n;
  owner_t      owner_n;
  logic        tmr_load;
  logic [TW-1:0] tmr_val;
  logic        tmr_expire;
  logic [1:0]  step_inc;

  tick_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      step        <= 2'd0;
      min_done    <= 1'b0;
      num         <= 2'd0;
      play        <= 1'b0;
      simon_ack   <= 1'b0;
      owner       <= OWN_NONE;
      jingle_done <= 1'b0;
    end else begin
      state       <= state_n;
      step        <= step_n;
      min_done    <= min_done_n;
      num         <= num_n;
      play        <= play_n;
      simon_ack   <= ack_n;
      owner       <= owner_n;
      jingle_done <= (state_n == ST_DONE);
    end
  end

  // Next state, timer control and next output values.
  always_comb begin
    state_n    = state;
    step_n     = step;
    min_done_n = min_done;
    num_n      = num;
    ack_n      = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    step_inc   = step + 2'd1;

    if (game_over && state != ST_JINGLE && state != ST_DONE) begin
      // Abort whatever is sounding; an aborted Simon note is never acked.
      state_n  = ST_JINGLE;
      step_n   = 2'd0;
      num_n    = JINGLE_SEQ[0];
      tmr_load = 1'b1;
      tmr_val  = TW'(JINGLE_STEP);
    end else begin
      case (state)
        ST_IDLE: begin
          if (player_req) begin
            state_n    = ST_PNOTE;
            num_n      = player_num;
            min_done_n = 1'b0;
            tmr_load   = 1'b1;
            tmr_val    = TW'(MIN_TICKS);
          end else if (simon_req && !simon_ack) begin
            // simon_req is still high while the ack is visible; skip that cycle.
            state_n  = ST_SNOTE;
            num_n    = simon_num;
            tmr_load = 1'b1;
            tmr_val  = TW'(NOTE_TICKS);
          end
        end
        ST_SNOTE: begin
          if (tmr_expire) begin
            state_n  = ST_SGAP;
            tmr_load = 1'b1;
            tmr_val  = TW'(GAP_TICKS);
          end
        end
        ST_SGAP: begin
          if (tmr_expire) begin
            state_n = ST_IDLE;
            ack_n   = 1'b1;
          end
        end
        ST_PNOTE: begin
          if (tmr_expire) min_done_n = 1'b1;
          if ((min_done || tmr_expire) && !player_req) state_n = ST_IDLE;
        end
        ST_JINGLE: begin
          if (!game_over) begin
            state_n = ST_IDLE;
          end else if (tmr_expire) begin
            if (step == 2'(JINGLE_LEN - 1)) begin
              state_n = ST_DONE;
            end else begin
              step_n   = step_inc;
              num_n    = JINGLE_SEQ[step_inc];
              tmr_load = 1'b1;
              tmr_val  = TW'(JINGLE_STEP);
            end
          end
        end
        ST_DONE: begin
          if (!game_over) state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end

    play_n = (state_n == ST_SNOTE) || (state_n == ST_PNOTE) || (state_n == ST_JINGLE);

    case (state_n)
      ST_SNOTE, ST_SGAP:  owner_n = OWN_SIMON;
      ST_PNOTE:           owner_n = OWN_PLAYER;
      ST_JINGLE, ST_DONE: owner_n = OWN_JINGLE;
      default:            owner_n = OWN_NONE;
    endcase
  end

endmodule

// File: doc/tone_scheduler.md
TONE_SCHEDULER -- requirements
Module: tone_scheduler

Interface
REQ-001 SHALL have parameter NOTE_TICKS, 25_000_000, clk cycles a Simon note sounds.
REQ-002 SHALL have parameter GAP_TICKS, 5_000_000, silent cycles after each Simon note.
REQ-003 SHALL have parameter MIN_TICKS, 5_000_000, minimum cycles a player note sounds.
REQ-004 SHALL have parameter JINGLE_STEP, 10_000_000, cycles per game-over jingle step.
REQ-005 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port simon_req  input  1  Simon requests a note; held high until simon_ack.
REQ-008 SHALL have port simon_num  input  2  Simon note index, sampled at acceptance.
REQ-009 SHALL have port player_req  input  1  player button held (level).
REQ-010 SHALL have port player_num  input  2  player note index, sampled at acceptance.
REQ-011 SHALL have port game_over  input  1  game-over level.
REQ-012 SHALL have port num  output  2  note index driven to tone/LED datapath.
REQ-013 SHALL have port play  output  1  tone/LED enable.
REQ-014 SHALL have port simon_ack  output  1  one-cycle pulse: Simon note plus gap completed.
REQ-015 SHALL have port owner  output  2  current user: 0 none, 1 Simon, 2 player, 3 jingle.
REQ-016 SHALL have port jingle_done  output  1  high after jingle finishes until game_over low.

Function
REQ-017 SHALL implement FSM states IDLE, SNOTE, SGAP, PNOTE, JINGLE, DONE.
REQ-018 SHALL, in IDLE, accept by priority game_over > player_req > simon_req; the cycle after acceptance play/num/owner reflect the new state.
REQ-019 SHALL, on game_over high while not in JINGLE/DONE, abort any note immediately and enter JINGLE with step 0; aborted Simon note gets no simon_ack.
REQ-020 SHALL, in SNOTE, drive play=1, num=latched simon_num for exactly NOTE_TICKS cycles, then SGAP.
REQ-021 SHALL, in SGAP, drive play=0 for exactly GAP_TICKS cycles, then pulse simon_ack for one cycle while returning to IDLE.
REQ-022 SHALL not re-accept simon_req in the cycle simon_ack is high.
REQ-023 SHALL, in PNOTE, drive play=1, num=latched player_num until both player_req low and MIN_TICKS elapsed, then IDLE; player_num changes during PNOTE ignored.
REQ-024 SHALL not preempt SNOTE/SGAP by player_req; player_req waits for IDLE.
REQ-025 SHALL, in JINGLE, play JINGLE_SEQ[0..3] each for JINGLE_STEP cycles with play=1, then enter DONE.
REQ-026 SHALL, in DONE, drive play=0, jingle_done=1; return to IDLE when game_over low.
REQ-027 SHALL, in JINGLE, return to IDLE (jingle cut) if game_over falls.
REQ-028 SHALL use tick counters wide enough for the largest parameter; counts are exact, no off-by-one.

Reset
REQ-029 SHALL on reset low asynchronously force IDLE, num=0, play=0, simon_ack=0, owner=0, jingle_done=0, counters=0, mid-note included.
REQ-030 SHALL leave reset synchronously on the first clk edge with reset high.

Structure
REQ-031 SHALL place state enum, owner encoding, JINGLE_SEQ (3,2,1,0) and default tick constants in shared package simon_pkg.
REQ-032 SHALL use one sub-module tick_timer: loadable down-counter with one-cycle expire flag.

Verification (NOTE_TICKS=8, GAP_TICKS=4, MIN_TICKS=3, JINGLE_STEP=5)
REQ-033 SHALL check: simon_req=1, simon_num=2 in IDLE -> play=1,num=2 for 8 cycles, play=0 for 4, simon_ack one pulse, owner 1 then 0.
REQ-034 SHALL check: player_req held 1 cycle, num=1 -> play=1 for 3 cycles; held 10 cycles -> play=1 for 10 cycles.
REQ-035 SHALL check: simon_req and player_req same cycle -> player note first, Simon note after, simon_ack once.
REQ-036 SHALL check: game_over at SNOTE cycle 4 -> next cycle owner=3, num sequence 3,2,1,0 x5 cycles, no simon_ack, jingle_done=1 until game_over low.
REQ-037 SHALL check: reset low mid-PNOTE -> play=0, owner=0 immediately, before next clk edge.
